// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator keypad front end and entry stage.
//   digit_state_e     : digit FSM states (IDLE, LOAD, ACTIVE, WAIT_REL)
//   ADD/SUB/MUL/DIV   : operator bit indices within op_raw and the op latch
//   DB_CYCLES_DEFAULT : default debounce sample period (20 ms at 50 MHz)
//   is_onehot10       : true when exactly one of ten digit bits is set
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        ACTIVE   = 2'd2,
        WAIT_REL = 2'd3
    } digit_state_e;

    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int MUL = 2;
    localparam int DIV = 3;

    localparam int NUM_DIGITS        = 10;
    localparam int NUM_OPS           = 4;
    localparam int DB_CYCLES_DEFAULT = 1_000_000;

    // v & (v - 1) clears the lowest set bit, so a zero result means at most one bit
    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/keypad_frontend_debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Two-flop synchroniser, free-running sample tick and two-sample debouncer for
// W active-low raw inputs. Outputs are active-high.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : synchronous active-low reset (all inputs seen as released)
//   raw_i   in  : raw active-low buttons
//   d_o     out : debounced active-high levels (registered)
//   tick_o  out : one-cycle pulse when the sample counter wraps
// -----------------------------------------------------------------------------
module debounce_bank
    import calc_pkg::*;
#(
    parameter int W         = 15,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] d_o,
    output logic         tick_o
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [W-1:0]  samp_q;
    logic [W-1:0]  d_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  p_s;
    logic [W-1:0]  eq_s;
    logic          tick_s;

    assign p_s    = ~sync2_q;
    assign tick_s = (cnt_q == CNT_LAST);
    // a bit is allowed to move only when this sample agrees with the previous one
    assign eq_s   = ~(p_s ^ samp_q);
    assign d_o    = d_q;
    assign tick_o = tick_s;

    // two-flop synchroniser, reset to released (raw high)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // free-running sample period counter, never stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // sample and debounced state advance only on ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q <= '0;
            d_q    <= '0;
        end else if (tick_s) begin
            samp_q <= p_s;
            d_q    <= (d_q & ~eq_s) | (p_s & eq_s);
        end else begin
            samp_q <= samp_q;
            d_q    <= d_q;
        end
    end

endmodule

// File: rtl/keypad_frontend.sv
// -----------------------------------------------------------------------------
// keypad_frontend
// Conditions raw calculator buttons for the entry stage: digits become a
// latched one-hot KEY plus an append level, operators a latched one-hot level,
// set a clean level delayed so a same-cycle operator is stable first.
// Ports:
//   clk      in  : 50 MHz system clock
//   rst_n    in  : synchronous active-low reset
//   key_raw  in  : [9:0] digit buttons, active-low
//   op_raw   in  : [3:0] add/sub/mul/div buttons, active-low
//   set_raw  in  : set button, active-low
//   KEY      out : latched one-hot digit, stable while append is high
//   append   out : digit-valid level
//   set      out : debounced set level, delayed 2 clk from debounce
//   Add/Sub/Mul/Div out : latched one-hot operator
// Optional feature: define KEYPAD_AUTOREPEAT_EN to enable auto-repeat of a
// held digit (append drops for one tick every REPEAT_TICKS held ticks).
// -----------------------------------------------------------------------------
module keypad_frontend
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_TICKS = 25
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_raw,
    input  logic [3:0] op_raw,
    input  logic       set_raw,
    output logic [9:0] KEY,
    output logic       append,
    output logic       set,
    output logic       Add,
    output logic       Sub,
    output logic       Mul,
    output logic       Div
);

    localparam int NB = NUM_DIGITS + NUM_OPS + 1;

    logic [NB-1:0] raw_s;
    logic [NB-1:0] deb_s;
    logic [9:0]    dk_s;
    logic [3:0]    dop_s;
    logic          dset_s;
    logic [3:0]    op_rise_s;
    logic [3:0]    op_d;

    digit_state_e  state_q;
    logic [9:0]    key_q;
    logic          append_q;
    logic [3:0]    dop_q;
    logic [3:0]    op_q;
    logic          set_dly_q;
    logic          set_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RW       = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic          tick_s;
    logic [RW-1:0] rep_cnt_q;
    logic          gap_q;
`endif

    assign raw_s  = {set_raw, op_raw, key_raw};
    assign dk_s   = deb_s[9:0];
    assign dop_s  = deb_s[13:10];
    assign dset_s = deb_s[14];

    debounce_bank #(
        .W         (NB),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (raw_s),
        .d_o    (deb_s),
`ifdef KEYPAD_AUTOREPEAT_EN
        .tick_o (tick_s)
`else
        .tick_o ()
`endif
    );

    assign op_rise_s = dop_s & ~dop_q;

    // operator latch next value: highest-priority rising op wins, else hold
    always_comb begin
        op_d = op_q;
        if (op_rise_s[ADD]) begin
            op_d      = 4'b0000;
            op_d[ADD] = 1'b1;
        end else if (op_rise_s[SUB]) begin
            op_d      = 4'b0000;
            op_d[SUB] = 1'b1;
        end else if (op_rise_s[MUL]) begin
            op_d      = 4'b0000;
            op_d[MUL] = 1'b1;
        end else if (op_rise_s[DIV]) begin
            op_d      = 4'b0000;
            op_d[DIV] = 1'b1;
        end else begin
            op_d = op_q;
        end
    end

    // operator edge history, operator latch and two-stage set delay
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dop_q     <= 4'b0000;
            op_q      <= 4'b0000;
            set_dly_q <= 1'b0;
            set_q     <= 1'b0;
        end else begin
            dop_q     <= dop_s;
            op_q      <= op_d;
            set_dly_q <= dset_s;
            set_q     <= set_dly_q;
        end
    end

    // digit FSM with registered KEY and append
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= 10'd0;
            append_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= '0;
            gap_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    append_q <= 1'b0;
                    if (is_onehot10(dk_s)) begin
                        state_q <= LOAD;
                    end else if (dk_s != 10'd0) begin
                        state_q <= WAIT_REL;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    append_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_q <= '0;
                    gap_q     <= 1'b0;
`endif
                    // with a very short tick the digit may change here; never load a non-one-hot KEY
                    if (is_onehot10(dk_s)) begin
                        key_q   <= dk_s;
                        state_q <= ACTIVE;
                    end else begin
                        state_q <= WAIT_REL;
                    end
                end
                ACTIVE: begin
                    if (dk_s != key_q) begin
                        append_q <= 1'b0;
                        state_q  <= WAIT_REL;
                    end else begin
                        state_q <= ACTIVE;
`ifdef KEYPAD_AUTOREPEAT_EN
                        // high for REPEAT_TICKS tick boundaries, then low for exactly one tick period
                        if (!tick_s) begin
                            append_q <= ~gap_q;
                        end else if (gap_q) begin
                            gap_q     <= 1'b0;
                            rep_cnt_q <= '0;
                            append_q  <= 1'b1;
                        end else if (rep_cnt_q == REP_LAST) begin
                            gap_q    <= 1'b1;
                            append_q <= 1'b0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + RW'(1);
                            append_q  <= 1'b1;
                        end
`else
                        append_q <= 1'b1;
`endif
                    end
                end
                WAIT_REL: begin
                    append_q <= 1'b0;
                    if (dk_s == 10'd0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_REL;
                    end
                end
                default: begin
                    append_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign KEY    = key_q;
    assign append = append_q;
    assign set    = set_q;
    assign Add    = op_q[ADD];
    assign Sub    = op_q[SUB];
    assign Mul    = op_q[MUL];
    assign Div    = op_q[DIV];

endmodule

// File: tb/tb_keypad_frontend.sv
module tb_keypad_frontend;

    logic       clk;
    logic       rst_n;
    logic [9:0] key_raw;
    logic [3:0] op_raw;
    logic       set_raw;
    logic [9:0] KEY;
    logic       append;
    logic       set;
    logic       Add;
    logic       Sub;
    logic       Mul;
    logic       Div;

    logic [15:0] outs;
    int n_cmp;
    int n_err;

    assign outs = {KEY, append, set, Add, Sub, Mul, Div};

    keypad_frontend #(
        .DB_CYCLES (4)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_TICKS (3)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_raw),
        .op_raw  (op_raw),
        .set_raw (set_raw),
        .KEY     (KEY),
        .append  (append),
        .set     (set),
        .Add     (Add),
        .Sub     (Sub),
        .Mul     (Mul),
        .Div     (Div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n clocks, leaving time 1 unit after the last rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        key_raw = 10'h3FF;
        op_raw  = 4'hF;
        set_raw = 1'b1;
        step(3);
        n_cmp++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outs: got %b expected %b", outs, 16'h0000);
        end
        rst_n = 1'b1;
        step(12);
        n_cmp++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("FAIL idle_outs: got %b expected %b", outs, 16'h0000);
        end
    endtask

    task automatic test_glitch_press();
        int  rises;
        int  fall_at;
        logic prev;
        rises = 0;
        prev  = append;
        for (int i = 0; i < 40; i++) begin
            key_raw[7] = (i == 1 || i == 3 || i == 5) ? 1'b1 : 1'b0;
            step(1);
            if (append && !prev) rises++;
            prev = append;
        end
        n_cmp++;
        if (KEY !== 10'b0010000000) begin
            n_err++;
            $display("FAIL glitch_key: got %b expected %b", KEY, 10'b0010000000);
        end
        n_cmp++;
        if (append !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_append_held: got %b expected 1", append);
        end
        key_raw[7] = 1'b1;
        fall_at = 0;
        for (int j = 1; j <= 14; j++) begin
            step(1);
            if (append && !prev) rises++;
            if (!append && fall_at == 0) fall_at = j;
            prev = append;
        end
        n_cmp++;
        if (rises !== 1) begin
            n_err++;
            $display("FAIL glitch_rises: got %0d expected 1", rises);
        end
        // 2 sync + at most 2 tick periods (8) + 1 FSM clock
        n_cmp++;
        if (fall_at == 0 || fall_at > 11) begin
            n_err++;
            $display("FAIL glitch_release_latency: got %0d clk expected 1..11", fall_at);
        end
        n_cmp++;
        if (KEY !== 10'b0010000000) begin
            n_err++;
            $display("FAIL glitch_key_kept: got %b expected %b", KEY, 10'b0010000000);
        end
    endtask

    task automatic test_multi_key();
        logic seen_high;
        seen_high = 1'b0;
        key_raw = 10'b1111010111;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (append) seen_high = 1'b1;
        end
        n_cmp++;
        if (seen_high !== 1'b0) begin
            n_err++;
            $display("FAIL multi_append: got %b expected 0", seen_high);
        end
        n_cmp++;
        if (KEY !== 10'b0010000000) begin
            n_err++;
            $display("FAIL multi_key_unchanged: got %b expected %b", KEY, 10'b0010000000);
        end
        key_raw = 10'h3FF;
        step(14);
        key_raw = 10'b1111111011;
        step(16);
        n_cmp++;
        if (KEY !== 10'b0000000100) begin
            n_err++;
            $display("FAIL press2_key: got %b expected %b", KEY, 10'b0000000100);
        end
        n_cmp++;
        if (append !== 1'b1) begin
            n_err++;
            $display("FAIL press2_append: got %b expected 1", append);
        end
        key_raw = 10'h3FF;
        step(14);
    endtask

    task automatic test_extra_key();
        logic seen_high;
        key_raw = 10'b1111101111;
        step(16);
        n_cmp++;
        if ({KEY, append} !== {10'b0000010000, 1'b1}) begin
            n_err++;
            $display("FAIL hold4: got %b/%b expected %b/1", KEY, append, 10'b0000010000);
        end
        key_raw = 10'b1110101111;
        step(16);
        n_cmp++;
        if (append !== 1'b0) begin
            n_err++;
            $display("FAIL add6_append: got %b expected 0", append);
        end
        key_raw = 10'b1111101111;
        seen_high = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (append) seen_high = 1'b1;
        end
        n_cmp++;
        if (seen_high !== 1'b0) begin
            n_err++;
            $display("FAIL release6_append: got %b expected 0", seen_high);
        end
        key_raw = 10'h3FF;
        step(14);
        n_cmp++;
        if ({KEY, append} !== {10'b0000010000, 1'b0}) begin
            n_err++;
            $display("FAIL extra_released: got %b/%b expected %b/0", KEY, append, 10'b0000010000);
        end
    endtask

    task automatic test_op_set();
        int add_at;
        int set_at;
        add_at  = 0;
        set_at  = 0;
        op_raw  = 4'b1100;
        set_raw = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            if (Add && add_at == 0) add_at = j;
            if (set && set_at == 0) set_at = j;
        end
        n_cmp++;
        if ({Add, Sub, Mul, Div} !== 4'b1000) begin
            n_err++;
            $display("FAIL op_priority: got %b expected %b", {Add, Sub, Mul, Div}, 4'b1000);
        end
        n_cmp++;
        if (add_at == 0 || set_at == 0 || (set_at - add_at) < 1) begin
            n_err++;
            $display("FAIL op_before_set: got add@%0d set@%0d expected add at least 1 clk earlier", add_at, set_at);
        end
        op_raw  = 4'hF;
        set_raw = 1'b1;
        step(14);
        n_cmp++;
        if ({set, Add, Sub, Mul, Div} !== 5'b01000) begin
            n_err++;
            $display("FAIL op_hold_after_release: got %b expected %b", {set, Add, Sub, Mul, Div}, 5'b01000);
        end
        op_raw = 4'b1011;
        step(14);
        n_cmp++;
        if ({Add, Sub, Mul, Div} !== 4'b0010) begin
            n_err++;
            $display("FAIL op_mul: got %b expected %b", {Add, Sub, Mul, Div}, 4'b0010);
        end
        op_raw = 4'hF;
        step(14);
    endtask

    task automatic test_reset_mid_press();
        int rise_at;
        key_raw = 10'b1111111011;
        step(16);
        n_cmp++;
        if (append !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_active: got %b expected 1", append);
        end
        rst_n = 1'b0;
        step(1);
        n_cmp++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_outs: got %b expected %b", outs, 16'h0000);
        end
        rst_n   = 1'b1;
        rise_at = 0;
        for (int j = 1; j <= 24; j++) begin
            step(1);
            if (append && rise_at == 0) rise_at = j;
        end
        // sync at clk 2, first tick samples at clk 4, second tick debounces at clk 8, LOAD 9, KEY 10, append 11
        n_cmp++;
        if (rise_at !== 11) begin
            n_err++;
            $display("FAIL reset_repress_latency: got %0d expected 11", rise_at);
        end
        n_cmp++;
        if (KEY !== 10'b0000000100) begin
            n_err++;
            $display("FAIL reset_repress_key: got %b expected %b", KEY, 10'b0000000100);
        end
        key_raw = 10'h3FF;
        step(14);
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int   rise_t[$];
        logic prev;
        logic key_bad;
        int   bad_gap;
        key_bad = 1'b0;
        prev    = append;
        key_raw = 10'b0111111111;
        for (int j = 1; j <= 100; j++) begin
            step(1);
            if (append && !prev) rise_t.push_back(j);
            if (append && KEY !== 10'b1000000000) key_bad = 1'b1;
            prev = append;
        end
        n_cmp++;
        if (rise_t.size() < 5) begin
            n_err++;
            $display("FAIL repeat_count: got %0d rises expected at least 5", rise_t.size());
        end
        bad_gap = 0;
        for (int k = 1; k < rise_t.size(); k++) begin
            if (rise_t[k] - rise_t[k-1] != 16) bad_gap++;
        end
        n_cmp++;
        if (bad_gap != 0) begin
            n_err++;
            $display("FAIL repeat_period: got %0d intervals not 16 clk expected 0", bad_gap);
        end
        n_cmp++;
        if (key_bad !== 1'b0) begin
            n_err++;
            $display("FAIL repeat_key_stable: got %b expected 0", key_bad);
        end
        key_raw = 10'h3FF;
        step(14);
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_glitch_press();
        test_multi_key();
        test_extra_key();
        test_op_set();
        test_reset_mid_press();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
